// File: rtl/decode_queue.sv
// decode_queue: RV32 decode stage with a built-in DEPTH-entry circular FIFO.
// Raw instruction words are decoded as they are enqueued. The decoded bundle
// at the head of the queue is presented to issue.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   flush                 synchronous queue flush (drops same-cycle input)
//   in_valid/in_ready     fetch-side handshake
//   in_instr, in_pc       raw instruction word and its PC
//   out_valid/out_ready   issue-side handshake
//   out_*                 decoded fields of the head entry
//   count                 occupancy, 0..DEPTH

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ARCH_REG_INDEX_SIZE
`define ARCH_REG_INDEX_SIZE 5
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 3
`define INSTR_TYPE_NO_WB 3'd0
`define INSTR_TYPE_ALU   3'd1
`define INSTR_TYPE_MUL   3'd2
`define INSTR_TYPE_LOAD  3'd3
`define INSTR_TYPE_STORE 3'd4
`endif
`ifndef OPCODE_ALU
`define OPCODE_ALU     7'b0110011
`define OPCODE_ALU_IMM 7'b0010011
`define OPCODE_LOAD    7'b0000011
`define OPCODE_STORE   7'b0100011
`define OPCODE_BRANCH  7'b1100011
`define OPCODE_JUMP    7'b1101111
`define OPCODE_AUIPC   7'b0010111
`endif
`ifndef MUL_FUNCT7
`define MUL_FUNCT7 7'b0000001
`endif

module decode_queue #(
  parameter int DEPTH      = 4,
  parameter int INSTR_SIZE = `WORD_SIZE
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [INSTR_SIZE-1:0]             in_instr,
  input  logic [`WORD_SIZE-1:0]             in_pc,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [`WORD_SIZE-1:0]             out_pc,
  output logic [`ARCH_REG_INDEX_SIZE-1:0]   out_rs1,
  output logic [`ARCH_REG_INDEX_SIZE-1:0]   out_rs2,
  output logic [`ARCH_REG_INDEX_SIZE-1:0]   out_rd,
  output logic [`WORD_SIZE-1:0]             out_imm,
  output logic [`INSTR_TYPE_SZ-1:0]         out_instr_type,
  output logic [6:0]                        out_opcode,
  output logic [6:0]                        out_funct7,
  output logic [2:0]                        out_funct3,
  output logic                              out_illegal,
  output logic [$clog2(DEPTH):0]            count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OPCODE_LUI  = 7'b0110111;
  localparam logic [6:0] OPCODE_JALR = 7'b1100111;

  typedef struct packed {
    logic [`WORD_SIZE-1:0]            pc;
    logic [`ARCH_REG_INDEX_SIZE-1:0]  rs1;
    logic [`ARCH_REG_INDEX_SIZE-1:0]  rs2;
    logic [`ARCH_REG_INDEX_SIZE-1:0]  rd;
    logic [`WORD_SIZE-1:0]            imm;
    logic [`INSTR_TYPE_SZ-1:0]        instr_type;
    logic [6:0]                       opcode;
    logic [6:0]                       funct7;
    logic [2:0]                       funct3;
    logic                             illegal;
  } entry_t;

  entry_t             storage [DEPTH];
  entry_t             dec;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               enq;
  logic               deq;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every field gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    dec            = '0;
    dec.pc         = in_pc;
    dec.opcode     = in_instr[6:0];
    dec.rd         = in_instr[11:7];
    dec.funct3     = in_instr[14:12];
    dec.rs1        = in_instr[19:15];
    dec.rs2        = in_instr[24:20];
    dec.funct7     = in_instr[31:25];
    dec.instr_type = `INSTR_TYPE_NO_WB;

    unique case (in_instr[6:0])
      `OPCODE_ALU: begin
        dec.instr_type = (in_instr[31:25] == `MUL_FUNCT7) ? `INSTR_TYPE_MUL
                                                          : `INSTR_TYPE_ALU;
      end
      `OPCODE_ALU_IMM: begin
        dec.imm        = {{21{in_instr[31]}}, in_instr[30:20]};
        dec.instr_type = `INSTR_TYPE_ALU;
      end
      `OPCODE_LOAD: begin
        dec.imm        = {{21{in_instr[31]}}, in_instr[30:20]};
        dec.instr_type = `INSTR_TYPE_LOAD;
      end
      OPCODE_JALR: begin
        dec.imm        = {{21{in_instr[31]}}, in_instr[30:20]};
      end
      `OPCODE_STORE: begin
        dec.imm        = {{21{in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
        dec.instr_type = `INSTR_TYPE_STORE;
      end
      `OPCODE_BRANCH: begin
        dec.imm = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
      end
      `OPCODE_JUMP: begin
        dec.imm = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
      end
      `OPCODE_AUIPC, OPCODE_LUI: begin
        dec.imm        = {in_instr[31:12], 12'b0};
        dec.instr_type = `INSTR_TYPE_ALU;
      end
      default: begin
        // Unsupported opcode: still enqueued, flagged, no writeback, imm 0.
        dec.illegal = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshakes: both ready/valid come from the registered count only.
  // ---------------------------------------------------------------------------
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign enq       = in_valid && in_ready && !flush;
  assign deq       = out_valid && out_ready && !flush;

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural overflow wraps the pointers.
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage: flush leaves the contents alone, only reset clears them.
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is reset on purpose so the head fields read as 0
  // straight out of reset; this costs a reset net on every entry bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
    end else if (enq) begin
      storage[wr_ptr] <= dec;
    end
  end

  // Head fields are driven regardless of out_valid.
  assign out_pc         = storage[rd_ptr].pc;
  assign out_rs1        = storage[rd_ptr].rs1;
  assign out_rs2        = storage[rd_ptr].rs2;
  assign out_rd         = storage[rd_ptr].rd;
  assign out_imm        = storage[rd_ptr].imm;
  assign out_instr_type = storage[rd_ptr].instr_type;
  assign out_opcode     = storage[rd_ptr].opcode;
  assign out_funct7     = storage[rd_ptr].funct7;
  assign out_funct3     = storage[rd_ptr].funct3;
  assign out_illegal    = storage[rd_ptr].illegal;

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised decode stage with a built-in instruction buffer, sitting between fetch and issue. Accepts raw RV32 instruction words plus PC over a valid/ready handshake, decodes them at enqueue time, stores the decoded bundle in a DEPTH-entry circular FIFO, and presents the head entry to issue over a second valid/ready handshake. Compared with the purely combinational decoder it adds LUI/JALR support, illegal-opcode flagging, back-pressure buffering and a pipeline flush.

## Interface
Parameters:
- DEPTH, 4, number of FIFO entries; power of two, ≥ 2.
- INSTR_SIZE, `WORD_SIZE, instruction width (only 32 supported).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; empties the queue.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept this cycle.
- in_instr  in  INSTR_SIZE  raw instruction.
- in_pc  in  `WORD_SIZE  instruction PC.
- out_valid  out  1  head entry valid.
- out_ready  in  1  issue consumes head this cycle.
- out_pc  out  `WORD_SIZE  PC of head.
- out_rs1, out_rs2, out_rd  out  `ARCH_REG_INDEX_SIZE  instr[19:15], [24:20], [11:7].
- out_imm  out  `WORD_SIZE  sign-extended immediate.
- out_instr_type  out  `INSTR_TYPE_SZ  writeback class.
- out_opcode  out  7; out_funct7  out  7; out_funct3  out  3.
- out_illegal  out  1  opcode not in supported set.
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.

## Operation
- Decode is combinational on in_instr; result written into entry wr_ptr on enqueue (in_valid && in_ready && !flush).
- Supported opcodes: `OPCODE_ALU, `OPCODE_ALU_IMM, `OPCODE_LOAD, `OPCODE_STORE, `OPCODE_BRANCH, `OPCODE_JUMP, `OPCODE_AUIPC, LUI (7'b0110111), JALR (7'b1100111). Any other opcode: out_illegal=1, instr_type=`INSTR_TYPE_NO_WB, imm=0; entry still enqueued.
- Immediate select: I-format (ALU_IMM, LOAD, JALR) {{21{i[31]}},i[30:20]}; S (STORE) {{21{i[31]}},i[30:25],i[11:7]}; B (BRANCH) {{20{i[31]}},i[7],i[30:25],i[11:8],0}; U (AUIPC, LUI) {i[31:12],12'b0}; J (JUMP) {{12{i[31]}},i[19:12],i[20],i[30:21],0}; R-format imm=0.
- instr_type: ALU opcode with funct7==`MUL_FUNCT7 → `INSTR_TYPE_MUL; other ALU, ALU_IMM, AUIPC, LUI → `INSTR_TYPE_ALU; LOAD → `INSTR_TYPE_LOAD; STORE → `INSTR_TYPE_STORE; BRANCH, JUMP, JALR, illegal → `INSTR_TYPE_NO_WB.
- Dequeue on out_valid && out_ready && !flush; rd_ptr advances.
- Pointers are $clog2(DEPTH) bits, wrap modulo DEPTH; count tracks occupancy separately.
- in_ready = (count != DEPTH). Enqueue at full is never accepted, even with a same-cycle dequeue.
- out_valid = (count != 0); out_* data fields = storage[rd_ptr] regardless of out_valid.
- Simultaneous enqueue and dequeue with 0 < count < DEPTH: both occur, count unchanged.
- flush: has priority over enqueue and dequeue; next cycle rd_ptr=wr_ptr=0, count=0; same-cycle input is dropped; stored data is not cleared.

## Timing
- Reset (asynchronous, immediate): pointers 0, count 0, all storage 0 → out_valid=0, in_ready=1, all out_* data 0 (out_illegal=0). Reset mid-traffic discards all entries.
- Enqueue-to-output latency: 1 cycle. An instruction accepted at edge N into an empty queue gives out_valid=1 with its fields right after edge N.
- Throughput: one enqueue and one dequeue per cycle sustained.
- in_ready and out_valid depend only on registered count. There is no combinational path from in_valid or out_ready to either signal.
- Upstream must hold in_instr/in_pc stable while in_valid && !in_ready. The queue holds head data stable while out_valid && !out_ready.

## Test plan
- Reset then enqueue 0x00500093 (addi x1,x0,5) at PC 0x100 → next cycle out_valid=1, rd=1, rs1=0, imm=5, type ALU, illegal=0, count=1.
- DEPTH=4, out_ready=0, enqueue 5 instrs → in_ready falls after 4th, count=4, 5th held. Then out_ready=1 → PCs drained in order, wrap verified.
- Full queue, in_valid=1 and out_ready=1 same cycle → dequeue only, count 4→3, enqueue accepted the following cycle.
- Decode coverage: 0x02208033 (mul) → MUL; 0xFE000EE3 (beq, imm=-4) → imm=0xFFFFFFFC, NO_WB; 0x123450B7 (lui) → imm=0x12345000, ALU; 0x0000007F → illegal=1, NO_WB.
- With 3 entries queued, assert flush with in_valid=1 → next cycle count=0, out_valid=0, flushed input not enqueued. Next enqueue appears 1 cycle later.
- Assert reset asynchronously mid-stream (between edges) → out_valid=0 and count=0 immediately. After release, normal enqueue resumes.
